// File: rtl/intersection_sequencer_if.sv
// ============================================================================
// Module      : intersection_sequencer_if
// Description : Sensor/request inputs and signal-head outputs of the
//               intersection sequencer, bundled as one port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface intersection_sequencer_if;
    logic       ew_sense;
    logic       ped_request;
    logic       ns_red;
    logic       ns_yellow;
    logic       ns_green;
    logic       ew_red;
    logic       ew_yellow;
    logic       ew_green;
    logic       walk;
    logic [7:0] clock;
    logic [2:0] phase;

    modport master (
        output ew_sense, ped_request,
        input  ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green,
        input  walk, clock, phase
    );

    modport slave (
        input  ew_sense, ped_request,
        output ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green,
        output walk, clock, phase
    );
endinterface

`default_nettype wire

// File: rtl/intersection_sequencer.sv
// ============================================================================
// Module      : intersection_sequencer
// Description : Two-approach intersection phase sequencer with vehicle-sensor
//               extension, pedestrian walk grant and countdown export.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intersection_sequencer #(
    parameter int GREEN_T  = 60,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2,
    parameter int WALK_T   = 8,
    parameter int PED_REM  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    intersection_sequencer_if.slave  bus
);

    localparam logic [2:0] S_AR_NS = 3'd0;
    localparam logic [2:0] S_NS_G  = 3'd1;
    localparam logic [2:0] S_NS_Y  = 3'd2;
    localparam logic [2:0] S_AR_EW = 3'd3;
    localparam logic [2:0] S_EW_G  = 3'd4;
    localparam logic [2:0] S_EW_Y  = 3'd5;

    localparam logic [7:0] c_green  = 8'(GREEN_T - 1);
    localparam logic [7:0] c_yellow = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_allred = 8'(ALLRED_T - 1);
    localparam logic [7:0] c_walk   = 8'(WALK_T - 1);
    localparam logic [7:0] c_ped    = 8'(PED_REM - 1);

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic       r_ped_pend;
    logic       r_walk;
    logic       r_ns_red, r_ns_yellow, r_ns_green;
    logic       r_ew_red, r_ew_yellow, r_ew_green;

    logic [2:0] w_state_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_dec;
    logic       w_cnt_zero;
    logic       w_walk_nxt;
    logic       w_enter_ar;
    logic       w_grant;
    logic       w_shorten;
    logic       w_ped_pend_nxt;

    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_cnt_dec  = w_cnt_zero ? 8'd0 : (r_cnt - 8'd1);
    assign w_shorten  = r_ped_pend && (r_cnt > c_ped);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_dec;
        w_walk_nxt  = r_walk;
        w_enter_ar  = 1'b0;
        w_grant     = 1'b0;

        case (r_state)
            S_AR_NS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_NS_G;
                    w_cnt_nxt   = c_green;
                    w_walk_nxt  = 1'b0;
                end
            end
            S_NS_G: begin
                // Main road rests in green at zero until someone else needs the junction
                if (w_cnt_zero) begin
                    if (bus.ew_sense || r_ped_pend) begin
                        w_state_nxt = S_NS_Y;
                        w_cnt_nxt   = c_yellow;
                    end
                end else if (w_shorten) begin
                    w_cnt_nxt = c_ped;
                end
            end
            S_NS_Y: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_AR_EW;
                    w_enter_ar  = 1'b1;
                end
            end
            S_AR_EW: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_EW_G;
                    w_cnt_nxt   = c_green;
                    w_walk_nxt  = 1'b0;
                end
            end
            S_EW_G: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_EW_Y;
                    w_cnt_nxt   = c_yellow;
                end else if (w_shorten) begin
                    w_cnt_nxt = c_ped;
                end
            end
            S_EW_Y: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_AR_NS;
                    w_enter_ar  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_AR_NS;
                w_cnt_nxt   = c_allred;
                w_walk_nxt  = 1'b0;
            end
        endcase

        // All-red entry either serves a pending pedestrian or is a plain clearance
        if (w_enter_ar) begin
            if (r_ped_pend) begin
                w_cnt_nxt  = c_walk;
                w_walk_nxt = 1'b1;
                w_grant    = 1'b1;
            end else begin
                w_cnt_nxt  = c_allred;
                w_walk_nxt = 1'b0;
            end
        end
    end

    // A new press in the grant cycle survives so it is served at the next all-red
    assign w_ped_pend_nxt = bus.ped_request | (r_ped_pend & ~w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_AR_NS;
            r_cnt       <= c_allred;
            r_ped_pend  <= 1'b0;
            r_walk      <= 1'b0;
            r_ns_red    <= 1'b1;
            r_ns_yellow <= 1'b0;
            r_ns_green  <= 1'b0;
            r_ew_red    <= 1'b1;
            r_ew_yellow <= 1'b0;
            r_ew_green  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ped_pend  <= w_ped_pend_nxt;
            r_walk      <= w_walk_nxt;
            r_ns_green  <= (w_state_nxt == S_NS_G);
            r_ns_yellow <= (w_state_nxt == S_NS_Y);
            r_ns_red    <= (w_state_nxt != S_NS_G) && (w_state_nxt != S_NS_Y);
            r_ew_green  <= (w_state_nxt == S_EW_G);
            r_ew_yellow <= (w_state_nxt == S_EW_Y);
            r_ew_red    <= (w_state_nxt != S_EW_G) && (w_state_nxt != S_EW_Y);
        end
    end

    assign bus.ns_red    = r_ns_red;
    assign bus.ns_yellow = r_ns_yellow;
    assign bus.ns_green  = r_ns_green;
    assign bus.ew_red    = r_ew_red;
    assign bus.ew_yellow = r_ew_yellow;
    assign bus.ew_green  = r_ew_green;
    assign bus.walk      = r_walk;
    assign bus.clock     = r_cnt;
    assign bus.phase     = r_state;

endmodule

`default_nettype wire
